// File: rtl/ysyx_23060203_pkg.sv
// Shared definitions for the ysyx_23060203 AXI crossbars: window defaults,
// response codes, crossbar FSM states and target select.
// Pure declarations; no logic, no latency, no backpressure.
package ysyx_23060203_pkg;

  localparam logic [31:0] CLINT_BASE_DEFAULT = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK_DEFAULT = 32'h0000_FFFF;

  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    ERR
  } xbar_state_t;

  typedef enum logic {
    TGT_SOC,
    TGT_CLINT
  } xbar_tgt_t;

endpackage

// File: rtl/ysyx_23060203_addr_dec.sv
// CLINT window decoder: flags CLINT hits and CLINT requests it cannot serve.
// Purely combinational, zero latency.
// No handshake of its own; the caller decides when the result is used.
module ysyx_23060203_addr_dec
  import ysyx_23060203_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEFAULT
) (
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic        hit_clint,
  output logic        illegal
);

  // The CLINT only serves single-beat accesses of at most 32 bits.
  assign hit_clint = ((araddr & ~CLINT_MASK) == CLINT_BASE);
  assign illegal   = hit_clint && ((arlen != 8'd0) || (arsize > 3'd2));

endmodule

// File: rtl/ysyx_23060203_read_xbar.sv
// AXI read crossbar: one master to CLINT / SoC, with local SLVERR for bad CLINT reads.
// Latency: AR handshake N -> target arvalid N+1; local error beats start at N+1.
// Backpressure: one transaction outstanding; in_arready only in IDLE, R beats held while in_rready low.
module ysyx_23060203_read_xbar
  import ysyx_23060203_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  // master side
  input  logic [31:0]     in_araddr,
  input  logic            in_arvalid,
  output logic            in_arready,
  input  logic [ID_W-1:0] in_arid,
  input  logic [7:0]      in_arlen,
  input  logic [2:0]      in_arsize,
  input  logic [1:0]      in_arburst,
  output logic            in_rvalid,
  input  logic            in_rready,
  output logic [31:0]     in_rdata,
  output logic [1:0]      in_rresp,
  output logic            in_rlast,
  output logic [ID_W-1:0] in_rid,
  // CLINT read port
  output logic [31:0]     clint_araddr,
  output logic            clint_arvalid,
  input  logic            clint_arready,
  output logic [ID_W-1:0] clint_arid,
  output logic [7:0]      clint_arlen,
  output logic [2:0]      clint_arsize,
  output logic [1:0]      clint_arburst,
  input  logic            clint_rvalid,
  output logic            clint_rready,
  input  logic [31:0]     clint_rdata,
  input  logic [1:0]      clint_rresp,
  input  logic            clint_rlast,
  input  logic [ID_W-1:0] clint_rid,
  // SoC read port
  output logic [31:0]     soc_araddr,
  output logic            soc_arvalid,
  input  logic            soc_arready,
  output logic [ID_W-1:0] soc_arid,
  output logic [7:0]      soc_arlen,
  output logic [2:0]      soc_arsize,
  output logic [1:0]      soc_arburst,
  input  logic            soc_rvalid,
  output logic            soc_rready,
  input  logic [31:0]     soc_rdata,
  input  logic [1:0]      soc_rresp,
  input  logic            soc_rlast,
  input  logic [ID_W-1:0] soc_rid
);

  xbar_state_t     state_q, state_d;
  xbar_tgt_t       tgt_q, tgt_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [2:0]      arsize_q, arsize_d;
  logic [1:0]      arburst_q, arburst_d;
  logic [7:0]      cnt_q, cnt_d;

  logic hit_clint;
  logic illegal;

  // Decoding the incoming address in IDLE is equivalent to decoding the
  // captured one, and lets the target be registered alongside the fields.
  ysyx_23060203_addr_dec #(
    .CLINT_BASE (CLINT_BASE),
    .CLINT_MASK (CLINT_MASK)
  ) u_addr_dec (
    .araddr    (in_araddr),
    .arlen     (in_arlen),
    .arsize    (in_arsize),
    .hit_clint (hit_clint),
    .illegal   (illegal)
  );

  // State, target, captured AR fields and error beat counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tgt_q     <= TGT_SOC;
      araddr_q  <= '0;
      arid_q    <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state and all outputs; anything the current state does not drive stays 0,
  // which keeps the always-valid CLINT R channel off the master outside R.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    cnt_d     = cnt_q;

    in_arready    = 1'b0;
    in_rvalid     = 1'b0;
    in_rdata      = '0;
    in_rresp      = RESP_OKAY;
    in_rlast      = 1'b0;
    in_rid        = '0;

    clint_araddr  = '0;
    clint_arvalid = 1'b0;
    clint_arid    = '0;
    clint_arlen   = '0;
    clint_arsize  = '0;
    clint_arburst = '0;
    clint_rready  = 1'b0;

    soc_araddr    = '0;
    soc_arvalid   = 1'b0;
    soc_arid      = '0;
    soc_arlen     = '0;
    soc_arsize    = '0;
    soc_arburst   = '0;
    soc_rready    = 1'b0;

    case (state_q)
      IDLE: begin
        in_arready = 1'b1;
        if (in_arvalid) begin
          araddr_d  = in_araddr;
          arid_d    = in_arid;
          arlen_d   = in_arlen;
          arsize_d  = in_arsize;
          arburst_d = in_arburst;
          if (illegal) begin
            state_d = ERR;
            tgt_d   = TGT_CLINT;
            cnt_d   = in_arlen;
          end else if (hit_clint) begin
            state_d = AR;
            tgt_d   = TGT_CLINT;
          end else begin
            state_d = AR;
            tgt_d   = TGT_SOC;
          end
        end
      end

      AR: begin
        if (tgt_q == TGT_CLINT) begin
          clint_araddr  = araddr_q;
          clint_arvalid = 1'b1;
          clint_arid    = arid_q;
          clint_arlen   = arlen_q;
          clint_arsize  = arsize_q;
          clint_arburst = arburst_q;
          if (clint_arready) state_d = R;
        end else begin
          soc_araddr    = araddr_q;
          soc_arvalid   = 1'b1;
          soc_arid      = arid_q;
          soc_arlen     = arlen_q;
          soc_arsize    = arsize_q;
          soc_arburst   = arburst_q;
          if (soc_arready) state_d = R;
        end
      end

      R: begin
        if (tgt_q == TGT_CLINT) begin
          in_rvalid    = clint_rvalid;
          in_rdata     = clint_rdata;
          in_rresp     = clint_rresp;
          in_rlast     = clint_rlast;
          in_rid       = clint_rid;
          clint_rready = in_rready;
        end else begin
          in_rvalid    = soc_rvalid;
          in_rdata     = soc_rdata;
          in_rresp     = soc_rresp;
          in_rlast     = soc_rlast;
          in_rid       = soc_rid;
          soc_rready   = in_rready;
        end
        if (in_rvalid && in_rready && in_rlast) state_d = IDLE;
      end

      ERR: begin
        // cnt counts remaining beats minus one, so arlen=255 yields 256 beats.
        in_rvalid = 1'b1;
        in_rresp  = RESP_SLVERR;
        in_rid    = arid_q;
        in_rlast  = (cnt_q == 8'd0);
        if (in_rready) begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
